smbus_reg_bank: RTL
===================

Name: smbus_reg_bank

Overview:
- Parametrised SMBus-facing register bank behind the I2C slave engine; generalises the fixed 32 x 8-bit read-only status mirror.
- Each register is one of three kinds: RO status mirror, RW control register, or W1C sticky event register.
- Adds a command pointer with auto-increment for block read/write, a per-register write strobe and an interrupt summary.
- Sits between the I2C slave core (command/data side) and board logic (status inputs, control outputs).

Parameters:
- NUM_REGS, 32, number of implemented registers, 1..256.
- ADDR_W, 8, width of command/pointer.
- DATA_W, 8, register width.
- RW_MASK, {NUM_REGS{1'b0}}, bit i=1: register i is RW.
- W1C_MASK, {NUM_REGS{1'b0}}, bit i=1: register i is W1C sticky. Must not overlap RW_MASK. A register with neither bit set is RO.
- RST_VAL, {NUM_REGS*DATA_W{1'b0}}, flattened reset values for RW registers; slice i belongs to register i.
- AUTO_INC, 1, 1 enables pointer increment after each data access.
- UNMAP_RD, 8'hFF, read value for pointer >= NUM_REGS.

Ports:
- CLK_IN  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- I2C_CMD  in  ADDR_W  command byte (register address).
- I2C_CMD_VLD  in  1  one-cycle pulse; load pointer from I2C_CMD.
- I2C_DAT_I  in  DATA_W  write data.
- I2C_WREN  in  1  one-cycle write pulse.
- I2C_RDEN  in  1  one-cycle pulse; byte at pointer was consumed.
- I2C_DAT_O  out  DATA_W  registered read data for current pointer.
- iREG_IN  in  NUM_REGS*DATA_W  flattened status inputs; used by RO and W1C registers.
- oREG_OUT  out  NUM_REGS*DATA_W  flattened current register contents.
- oWR_STB  out  NUM_REGS  one-cycle pulse, bit i, on an accepted write to register i.
- oIRQ  out  1  OR of all W1C register bits, registered.

Behaviour:
Reset (RESET high at a CLK_IN edge; dominates all other inputs that cycle):
- ptr=0; RW regs = RST_VAL; W1C regs = 0; RO sample regs = 0.
- I2C_DAT_O=0, oWR_STB=0, oIRQ=0.

Input sampling:
- iREG_IN registered once per cycle (in_q).
- RO register value = in_q.

Pointer, priority per cycle:
- CMD_VLD: ptr <= I2C_CMD. Any WREN/RDEN in the same cycle is dropped entirely: no write, no increment.
- Else WREN or RDEN (both high counts as one access, the write is performed): if AUTO_INC=1, the access increments the pointer as follows.
  - ptr < NUM_REGS-1: ptr+1.
  - ptr == NUM_REGS-1: wrap to 0.
  - ptr >= NUM_REGS: hold.

Write (WREN accepted, ptr < NUM_REGS):
- RW: reg <= I2C_DAT_I; oWR_STB[ptr]=1 next cycle.
- W1C: bits with I2C_DAT_I=1 are cleared; oWR_STB[ptr]=1 next cycle.
- RO: data ignored; oWR_STB[ptr]=1 next cycle (firmware "kick" usage).
- ptr >= NUM_REGS: ignored; no strobe.

W1C sticky:
- Each cycle, bit <= bit | in_q bit, with the write-clear applied first.
- Set wins over clear in the same cycle, so an event coincident with a clear stays latched.

Read path:
- I2C_DAT_O <= mux(ptr) every cycle, giving 1-cycle latency after the pointer or register changes.
- mux returns UNMAP_RD when ptr >= NUM_REGS.
- The slave core samples I2C_DAT_O no earlier than 2 cycles after CMD_VLD or RDEN.

Other outputs:
- oREG_OUT is the live register state.
- oIRQ is the registered OR of all W1C bits (1 cycle behind the bits).

Arithmetic:
- ptr is ADDR_W bits; the comparison with NUM_REGS is unsigned.
- NUM_REGS=2^ADDR_W: the unmapped range is empty and the wrap occurs at all-ones.

Decomposition:
- Package smbus_regs_pkg holds:
  - access-kind encoding KIND_RO/KIND_RW/KIND_W1C (2-bit localparams);
  - default DATA_W=8;
  - function kind_of(i, RW_MASK, W1C_MASK).
- Sub-module smbus_reg_cell: one DATA_W register with a kind parameter; handles write, W1C set/clear and the write strobe.
- The bank instantiates NUM_REGS cells in a generate loop and owns the pointer, read mux and oIRQ.

Test Plan:
Config for all cases: NUM_REGS=32, RW_MASK=32'h0000_0080 (reg 0x07), W1C_MASK=32'h0001_0000 (reg 0x10), RST_VAL slice 7 = 8'h5A.
- Reset, then CMD_VLD with CMD=0x07, wait 2 cycles -> I2C_DAT_O=8'h5A, oREG_OUT[0x07]=8'h5A, oIRQ=0.
- CMD=0x07, WREN with DAT_I=0x3C -> reg 0x07=0x3C, oWR_STB[7] pulses 1 cycle, ptr=0x08. Write to 0x03 (RO) -> reg unchanged, oWR_STB[3] pulses.
- iREG_IN slice 0x10 pulses 8'h81 for 1 cycle -> W1C reg 0x10=0x81, oIRQ=1. Write 0x01 -> reg=0x80. Write 0x80 in the same cycle an input 0x80 arrives -> reg stays 0x80 (set wins).
- CMD=0x1F, two RDEN pulses -> ptr goes 0x1F -> 0x00 -> 0x01 (wrap). CMD=0x40, RDEN -> ptr holds 0x40, I2C_DAT_O=0xFF, WREN ignored, no strobe.
- CMD_VLD and WREN in the same cycle -> pointer loaded, no write, no strobe. WREN and RDEN together -> one write, single increment.
- Assert RESET mid block write (after 1 of 3 bytes) -> all outputs return to reset values the next cycle; reg 0x07 = 0x5A.

Source files
------------

// File: rtl/smbus_regs_pkg.sv
// Shared encodings and helpers for the SMBus register bank.
// Register kinds are resolved at elaboration time from the RW/W1C masks.
package smbus_regs_pkg;

  localparam logic [1:0] KIND_RO  = 2'd0;
  localparam logic [1:0] KIND_RW  = 2'd1;
  localparam logic [1:0] KIND_W1C = 2'd2;

  localparam int DEFAULT_DATA_W = 8;
  localparam int MAX_REGS       = 256;

  // RW takes precedence if a mask pair is misconfigured with an overlap
  function automatic logic [1:0] kind_of(input int i,
                                         input logic [MAX_REGS-1:0] rwMask,
                                         input logic [MAX_REGS-1:0] w1cMask);
    logic [7:0] idx;
    idx = 8'(i);
    if (rwMask[idx]) return KIND_RW;
    if (w1cMask[idx]) return KIND_W1C;
    return KIND_RO;
  endfunction

endpackage

// File: rtl/smbus_reg_cell.sv
// One bank register: RO status mirror, RW control or W1C sticky event.
// Emits a one-cycle write strobe for every accepted write regardless of kind.
module smbus_reg_cell
  import smbus_regs_pkg::*;
#(
  parameter logic [1:0]        KIND    = KIND_RO,
  parameter int                DATA_W  = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              CLK_IN,
  input  logic              RESET,
  input  logic              wrSel,
  input  logic [DATA_W-1:0] wrData,
  input  logic [DATA_W-1:0] statusIn,
  output logic [DATA_W-1:0] value,
  output logic              wrStb
);

  logic unusedSink;
  assign unusedSink = ^{statusIn, wrData};

  always_ff @(posedge CLK_IN) begin
    if (RESET) wrStb <= 1'b0;
    else       wrStb <= wrSel;
  end

  if (KIND == KIND_RW) begin : gRw
    always_ff @(posedge CLK_IN) begin
      if (RESET)      value <= RST_VAL;
      else if (wrSel) value <= wrData;
    end
  end else begin : gSampled
    logic [DATA_W-1:0] sampleQ;

    always_ff @(posedge CLK_IN) begin
      if (RESET) sampleQ <= '0;
      else       sampleQ <= statusIn;
    end

    if (KIND == KIND_W1C) begin : gW1c
      logic [DATA_W-1:0] clrBits;
      assign clrBits = wrSel ? wrData : '0;

      // Clear is applied before the OR so a coincident event stays latched
      always_ff @(posedge CLK_IN) begin
        if (RESET) value <= '0;
        else       value <= (value & ~clrBits) | sampleQ;
      end
    end else begin : gRo
      assign value = sampleQ;
    end
  end

endmodule

// File: rtl/smbus_reg_bank.sv
// SMBus-facing register bank: command pointer with optional auto-increment,
// registered read mux, per-register write strobes and a W1C interrupt summary.
module smbus_reg_bank
  import smbus_regs_pkg::*;
#(
  parameter int                         NUM_REGS = 32,
  parameter int                         ADDR_W   = 8,
  parameter int                         DATA_W   = DEFAULT_DATA_W,
  parameter logic [NUM_REGS-1:0]        RW_MASK  = '0,
  parameter logic [NUM_REGS-1:0]        W1C_MASK = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL  = '0,
  parameter bit                         AUTO_INC = 1'b1,
  parameter logic [DATA_W-1:0]          UNMAP_RD = '1
) (
  input  logic                       CLK_IN,
  input  logic                       RESET,
  input  logic [ADDR_W-1:0]          I2C_CMD,
  input  logic                       I2C_CMD_VLD,
  input  logic [DATA_W-1:0]          I2C_DAT_I,
  input  logic                       I2C_WREN,
  input  logic                       I2C_RDEN,
  output logic [DATA_W-1:0]          I2C_DAT_O,
  input  logic [NUM_REGS*DATA_W-1:0] iREG_IN,
  output logic [NUM_REGS*DATA_W-1:0] oREG_OUT,
  output logic [NUM_REGS-1:0]        oWR_STB,
  output logic                       oIRQ
);

  logic [ADDR_W-1:0] ptr;
  logic              ptrInRange;
  logic              ptrLast;
  logic              access;
  logic              wrAccept;
  logic [NUM_REGS-1:0] wrSel;
  logic [NUM_REGS-1:0] irqBits;
  logic [DATA_W-1:0]   regVal [NUM_REGS];
  logic [DATA_W-1:0]   rdMux;

  // Widened compare keeps NUM_REGS == 2**ADDR_W from overflowing
  assign ptrInRange = ({1'b0, ptr} < (ADDR_W+1)'(NUM_REGS));
  assign ptrLast    = (ptr == ADDR_W'(NUM_REGS - 1));
  assign access     = (I2C_WREN || I2C_RDEN) && !I2C_CMD_VLD;
  assign wrAccept   = I2C_WREN && !I2C_CMD_VLD && ptrInRange;

  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      ptr <= '0;
    end else if (I2C_CMD_VLD) begin
      ptr <= I2C_CMD;
    end else if (access && AUTO_INC) begin
      if (ptrLast)         ptr <= '0;
      else if (ptrInRange) ptr <= ptr + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : gCell
    localparam logic [1:0] KIND = kind_of(i, MAX_REGS'(RW_MASK), MAX_REGS'(W1C_MASK));

    assign wrSel[i] = wrAccept && (ptr == ADDR_W'(i));

    smbus_reg_cell #(
      .KIND    (KIND),
      .DATA_W  (DATA_W),
      .RST_VAL (RST_VAL[i*DATA_W +: DATA_W])
    ) uCell (
      .CLK_IN   (CLK_IN),
      .RESET    (RESET),
      .wrSel    (wrSel[i]),
      .wrData   (I2C_DAT_I),
      .statusIn (iREG_IN[i*DATA_W +: DATA_W]),
      .value    (regVal[i]),
      .wrStb    (oWR_STB[i])
    );

    assign oREG_OUT[i*DATA_W +: DATA_W] = regVal[i];
    assign irqBits[i] = (KIND == KIND_W1C) && (|regVal[i]);
  end

  always_comb begin
    rdMux = UNMAP_RD;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ptr == ADDR_W'(i)) rdMux = regVal[i];
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      I2C_DAT_O <= '0;
      oIRQ      <= 1'b0;
    end else begin
      I2C_DAT_O <= rdMux;
      oIRQ      <= |irqBits;
    end
  end

endmodule
